vga_coord_bars: RTL

Parametrised VGA display controller for the robotic-arm coordinate readout. It generates VGA timing from MAX10_CLK1_50 through an internal pixel-enable divider. It renders N_CH coordinate channels as horizontal bar graphs or position markers over a bordered background. Coordinates are shadow-latched at the start of vertical blanking, so a frame never tears. It replaces the fixed 640×480 coordinate overlay at the top of the VGA path and drives the board VGA pins directly.

---
 rtl/vga_coord_bars.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/vga_coord_bars.sv
// rtl/vga_coord_bars.sv - VGA timing plus N_CH coordinate bar/marker renderer
//
// Ports:
//   MAX10_CLK1_50  system clock; pixels advance every CLK_DIV cycles
//   rst_n          asynchronous active-low reset
//   coords         N_CH packed coordinates, channel k at [k*COORD_W +: COORD_W]
//   mode           0 = bar graph, 1 = 4-pixel position marker
//   hsync_out      horizontal sync, active level HS_POL
//   vsync_out      vertical sync, active level VS_POL
//   VGA_R/G/B      4-bit colour, 000 outside the active area
//   frame_start    one-clock pulse on the pixel that wraps the frame
//   frame_count    completed-frame counter, wraps at 16 bits
module vga_coord_bars #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int N_CH     = 3,
    parameter int COORD_W  = 10,
    parameter int BAR_H    = 32,
    parameter int BAR_GAP  = 16
) (
    input  logic                    MAX10_CLK1_50,
    input  logic                    rst_n,
    input  logic [N_CH*COORD_W-1:0] coords,
    input  logic                    mode,
    output logic                    hsync_out,
    output logic                    vsync_out,
    output logic [3:0]              VGA_R,
    output logic [3:0]              VGA_G,
    output logic [3:0]              VGA_B,
    output logic                    frame_start,
    output logic [15:0]             frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PW      = COORD_W + 11;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [HW-1:0]    H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]    V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]    V_LATCH  = VW'(V_ACTIVE - 1);

    logic [DIV_W-1:0]        div;
    logic                    pix_en;
    logic [HW-1:0]           h;
    logic [VW-1:0]           v;
    logic                    h_wrap;
    logic                    frame_wrap;
    logic                    latch_now;
    logic [N_CH*COORD_W-1:0] shadow_coords;
    logic                    shadow_mode;
    logic                    hs_act;
    logic                    vs_act;
    logic [11:0]             rgb_next;

    // Render scratch, all written with defaults before use in always_comb.
    int                      px;
    int                      py;
    int                      row_lo;
    int                      len;
    logic [PW-1:0]           prod;
    logic                    ch_hit;
    logic [11:0]             ch_rgb;

    function automatic logic [11:0] ch_colour(input int k);
        case (k)
            0:       ch_colour = 12'hF00;
            1:       ch_colour = 12'h0F0;
            2:       ch_colour = 12'h00F;
            default: ch_colour = 12'hFFF;
        endcase
    endfunction

    assign pix_en     = (div == DIV_LAST);
    assign h_wrap     = (h == H_LAST);
    assign frame_wrap = h_wrap && (v == V_LAST);
    // Latch on the last pixel of the last active line so the whole next
    // frame renders from one consistent coordinate set.
    assign latch_now  = h_wrap && (v == V_LATCH);

    always_comb begin
        hs_act = (int'(h) >= H_ACTIVE + H_FP) && (int'(h) < H_ACTIVE + H_FP + H_SYNC);
        vs_act = (int'(v) >= V_ACTIVE + V_FP) && (int'(v) < V_ACTIVE + V_FP + V_SYNC);
    end

    always_comb begin
        px       = int'(h);
        py       = int'(v);
        row_lo   = 0;
        len      = 0;
        prod     = '0;
        ch_hit   = 1'b0;
        ch_rgb   = 12'h000;
        rgb_next = 12'h000;

        // Rows are disjoint, so at most one channel can claim a pixel.
        for (int k = 0; k < N_CH; k++) begin
            row_lo = BAR_GAP + k * (BAR_H + BAR_GAP);
            prod   = PW'(shadow_coords[k*COORD_W +: COORD_W]) * PW'(H_ACTIVE);
            len    = int'(prod >> COORD_W);
            if (py >= row_lo && py < row_lo + BAR_H) begin
                // Marker clipping at the right edge falls out of the
                // active-area gate below.
                if (shadow_mode ? (px >= len && px <= len + 3) : (px < len)) begin
                    ch_hit = 1'b1;
                    ch_rgb = ch_colour(k);
                end
            end
        end

        if (px < H_ACTIVE && py < V_ACTIVE) begin
            if (px == 0 || px == H_ACTIVE - 1 || py == 0 || py == V_ACTIVE - 1) begin
                rgb_next = 12'hFFF;
            end else if (ch_hit) begin
                rgb_next = ch_rgb;
            end else begin
                rgb_next = 12'h113;
            end
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (pix_en) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            h             <= '0;
            v             <= '0;
            shadow_coords <= '0;
            shadow_mode   <= 1'b0;
        end else if (pix_en) begin
            h <= h_wrap ? '0 : h + HW'(1);
            if (h_wrap) begin
                v <= (v == V_LAST) ? '0 : v + VW'(1);
            end
            if (latch_now) begin
                shadow_coords <= coords;
                shadow_mode   <= mode;
            end
        end
    end

    // Outputs reflect the pixel present before the increment, giving sync
    // and colour the same single pixel of latency.
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            hsync_out              <= ~HS_POL;
            vsync_out              <= ~VS_POL;
            {VGA_R, VGA_G, VGA_B}  <= 12'h000;
            frame_start            <= 1'b0;
            frame_count            <= 16'd0;
        end else begin
            frame_start <= pix_en && frame_wrap;
            if (pix_en) begin
                hsync_out             <= hs_act ? HS_POL : ~HS_POL;
                vsync_out             <= vs_act ? VS_POL : ~VS_POL;
                {VGA_R, VGA_G, VGA_B} <= rgb_next;
                if (frame_wrap) begin
                    frame_count <= frame_count + 16'd1;
                end
            end
        end
    end

endmodule
